// File: rtl/cdp_tx_dispatch.sv
// CDP-side transmit dispatcher: buffers one UM packet at a time, then replays it
// onto the shared output bus for the port selected by the packet's forwarding rule.
module cdp_tx_dispatch #(
    parameter int DATA_AW    = 8,
    parameter int RULE_DEPTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         um2cdp_rule_wrreq,
    input  logic [29:0]  um2cdp_rule,
    input  logic         um2cdp_data_valid,
    input  logic [138:0] um2cdp_data,
    output logic [4:0]   cdp2um_rule_usedw,
    output logic         cdp2um_tx_enable,
    input  logic [3:0]   port_ready,
    output logic [138:0] out_data,
    output logic [3:0]   out_valid,
    output logic [15:0]  drop_cnt,
    output logic [2:0]   dbg_state_o
);
    localparam int RULE_AW = $clog2(RULE_DEPTH);
    localparam int DEPTH   = 1 << DATA_AW;
    localparam int LW      = DATA_AW + 1;
    localparam logic [LW-1:0] LEN_ONE = LW'(1);

    typedef enum logic [2:0] {IDLE, GRANT, RECV, SEND, DROP} state_t;

    state_t              state_q;
    logic [3:0]          port_sel_q;
    logic [LW-1:0]       len_q;
    logic [LW-1:0]       rd_ptr_q;
    logic                err_q;
    logic                done_q;
    logic                tx_en_q;
    logic                rd_vld_q;
    logic [138:0]        rd_data_q;
    logic [138:0]        out_data_q;
    logic [3:0]          out_valid_q;
    logic [15:0]         drop_q;

    // Rule FIFO: only the port bitmap is kept, the reserved rule bits are never used.
    logic [3:0]          rule_mem [RULE_DEPTH];
    logic [RULE_AW-1:0]  rule_wp_q, rule_rp_q;
    logic [RULE_AW:0]    rule_cnt_q, rule_cnt_d;
    logic                rule_wr, rule_pop;

    assign rule_wr    = um2cdp_rule_wrreq && !rule_cnt_q[RULE_AW];
    assign rule_pop   = (state_q == IDLE) && (rule_cnt_q != '0);
    assign rule_cnt_d = rule_cnt_q + (RULE_AW+1)'(rule_wr) - (RULE_AW+1)'(rule_pop);

    always_ff @(posedge clk) begin
        if (rule_wr) rule_mem[rule_wp_q] <= um2cdp_rule[3:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rule_wp_q  <= '0;
            rule_rp_q  <= '0;
            rule_cnt_q <= '0;
        end else begin
            if (rule_wr)  rule_wp_q <= rule_wp_q + 1'b1;
            if (rule_pop) rule_rp_q <= rule_rp_q + 1'b1;
            rule_cnt_q <= rule_cnt_d;
        end
    end

    // Packet buffer; words past the last address are discarded and flag the packet.
    logic [138:0] buf_mem [DEPTH];
    logic         buf_we;
    logic         is_tail;
    logic         port_ok;

    assign is_tail = (um2cdp_data[138:136] == 3'b110);
    assign buf_we  = um2cdp_data_valid &&
                     ((state_q == GRANT) || (state_q == RECV && !done_q && !len_q[DATA_AW]));

    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[len_q[DATA_AW-1:0]] <= um2cdp_data;
        rd_data_q <= buf_mem[rd_ptr_q[DATA_AW-1:0]];
    end

    always_comb begin
        case (port_sel_q)
            4'h1, 4'h2, 4'h4, 4'h8: port_ok = 1'b1;
            default:                port_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            port_sel_q  <= '0;
            len_q       <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            tx_en_q     <= 1'b0;
            rd_vld_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= '0;
            drop_q      <= '0;
        end else begin
            rd_vld_q <= (state_q == SEND) && (rd_ptr_q != len_q);
            out_valid_q <= rd_vld_q ? port_sel_q : 4'h0;
            if (rd_vld_q) out_data_q <= rd_data_q;

            case (state_q)
                IDLE: begin
                    len_q  <= '0;
                    err_q  <= 1'b0;
                    done_q <= 1'b0;
                    if (rule_pop) begin
                        port_sel_q <= rule_mem[rule_rp_q];
                        tx_en_q    <= 1'b1;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    if (um2cdp_data_valid) begin
                        tx_en_q <= 1'b0;
                        len_q   <= LEN_ONE;
                        done_q  <= is_tail;
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    if (!done_q) begin
                        if (um2cdp_data_valid) begin
                            if (len_q[DATA_AW]) err_q <= 1'b1;
                            else                len_q <= len_q + LEN_ONE;
                            if (is_tail)        done_q <= 1'b1;
                        end
                    end else if (err_q || !port_ok) begin
                        state_q <= DROP;
                    end else if ((port_ready & port_sel_q) != 4'h0) begin
                        rd_ptr_q <= '0;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    if (rd_ptr_q == len_q) state_q  <= IDLE;
                    else                   rd_ptr_q <= rd_ptr_q + LEN_ONE;
                end
                DROP: begin
                    if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
                    len_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cdp2um_rule_usedw = rule_cnt_q[RULE_AW-1:0];
    assign cdp2um_tx_enable  = tx_en_q;
    assign out_data          = out_data_q;
    assign out_valid         = out_valid_q;
    assign drop_cnt          = drop_q;
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_cdp_tx_dispatch.sv
// Bench for cdp_tx_dispatch: drives rules and packets as UM would and checks the
// replayed output words against an expected-word queue.
module tb_cdp_tx_dispatch;
    logic         clk = 1'b0;
    logic         reset;
    logic         um2cdp_rule_wrreq;
    logic [29:0]  um2cdp_rule;
    logic         um2cdp_data_valid;
    logic [138:0] um2cdp_data;
    logic [4:0]   cdp2um_rule_usedw;
    logic         cdp2um_tx_enable;
    logic [3:0]   port_ready;
    logic [138:0] out_data;
    logic [3:0]   out_valid;
    logic [15:0]  drop_cnt;
    logic [2:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_drop = 0;
    int cyc      = 0;

    logic [138:0] exp_q[$];
    logic [3:0]   exp_port_q[$];
    logic [138:0] pkt[8];
    logic [138:0] mon_d;
    logic [3:0]   mon_p;

    cdp_tx_dispatch dut (
        .clk               (clk),
        .reset             (reset),
        .um2cdp_rule_wrreq (um2cdp_rule_wrreq),
        .um2cdp_rule       (um2cdp_rule),
        .um2cdp_data_valid (um2cdp_data_valid),
        .um2cdp_data       (um2cdp_data),
        .cdp2um_rule_usedw (cdp2um_rule_usedw),
        .cdp2um_tx_enable  (cdp2um_tx_enable),
        .port_ready        (port_ready),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .drop_cnt          (drop_cnt),
        .dbg_state_o       (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every output word must match the oldest expected word and port.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid !== 4'h0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: out_valid=%b out_data=%h, no word expected", out_valid, out_data);
            end else begin
                mon_d = exp_q.pop_front();
                mon_p = exp_port_q.pop_front();
                if (out_data !== mon_d || out_valid !== mon_p) begin
                    n_fail++;
                    $display("FAIL out_word: got port %b data %h, expected port %b data %h",
                             out_valid, out_data, mon_p, mon_d);
                end
            end
        end
    end

    function automatic logic [138:0] make_word(input logic [2:0] tag);
        logic [135:0] p;
        p = {$urandom(), $urandom(), $urandom(), $urandom(), 8'($urandom())};
        return {tag, p};
    endfunction

    task automatic build_packet(input int nw);
        for (int i = 0; i < nw; i++)
            pkt[i] = make_word(i == 0 ? 3'b101 : (i == nw - 1 ? 3'b110 : 3'b100));
    endtask

    task automatic write_rule(input logic [3:0] r);
        um2cdp_rule       = {26'($urandom()), r};
        um2cdp_rule_wrreq = 1'b1;
        @(negedge clk);
        um2cdp_rule_wrreq = 1'b0;
    endtask

    task automatic wait_tx_enable(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cdp2um_tx_enable === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_grant_timeout: tx_enable=%b after 200 cycles, expected 1", name, cdp2um_tx_enable);
        end
    endtask

    task automatic send_built(input string name, input int nw, input logic [3:0] port,
                              input bit emit, input bit gaps);
        bit ok;
        wait_tx_enable(name, ok);
        if (!ok) return;
        for (int i = 0; i < nw; i++) begin
            um2cdp_data_valid = 1'b1;
            um2cdp_data       = pkt[i];
            if (emit) begin
                exp_q.push_back(pkt[i]);
                exp_port_q.push_back(port);
            end
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if (cdp2um_tx_enable !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_tx_enable_fall: tx_enable=%b after head, expected 0", name, cdp2um_tx_enable);
                end
            end
            if (gaps && i != nw - 1) begin
                um2cdp_data_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        um2cdp_data_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d words still pending, expected 0", name, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_drop(input string name);
        n_checks++;
        if (drop_cnt !== 16'(exp_drop)) begin
            n_fail++;
            $display("FAIL %s_drop_cnt: got %0d, expected %0d", name, drop_cnt, exp_drop);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if (cdp2um_tx_enable !== 1'b0 || out_valid !== 4'h0 || out_data !== '0 ||
            drop_cnt !== 16'h0 || cdp2um_rule_usedw !== 5'h0) begin
            n_fail++;
            $display("FAIL %s_outputs: tx_en=%b out_valid=%b out_data=%h drop=%0d usedw=%0d, expected all 0",
                     name, cdp2um_tx_enable, out_valid, out_data, drop_cnt, cdp2um_rule_usedw);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        um2cdp_rule_wrreq = 1'b0;
        um2cdp_rule       = '0;
        um2cdp_data_valid = 1'b0;
        um2cdp_data       = '0;
        port_ready        = 4'hF;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("post_reset");
    endtask

    task automatic test_single_packet();
        int run;
        port_ready = 4'hF;
        write_rule(4'h1);
        n_checks++;
        if (cdp2um_tx_enable !== 1'b0 || cdp2um_rule_usedw !== 5'd1) begin
            n_fail++;
            $display("FAIL single_cycle1: tx_en=%b usedw=%0d, expected 0 and 1", cdp2um_tx_enable, cdp2um_rule_usedw);
        end
        @(negedge clk);
        n_checks++;
        if (cdp2um_tx_enable !== 1'b1 || cdp2um_rule_usedw !== 5'd0) begin
            n_fail++;
            $display("FAIL single_cycle2: tx_en=%b usedw=%0d, expected 1 and 0", cdp2um_tx_enable, cdp2um_rule_usedw);
        end
        build_packet(4);
        send_built("single", 4, 4'h1, 1'b1, 1'b0);
        for (int i = 0; i < 20 && out_valid === 4'h0; i++) @(negedge clk);
        run = 0;
        for (int i = 0; i < 10 && out_valid !== 4'h0; i++) begin
            run++;
            @(negedge clk);
        end
        n_checks++;
        if (run != 4) begin
            n_fail++;
            $display("FAIL single_burst_len: got %0d contiguous words, expected 4", run);
        end
        drain("single");
        check_drop("single");
    endtask

    task automatic test_multicast();
        int peak;
        logic [3:0] ports[4];
        ports = '{4'h1, 4'h2, 4'h4, 4'h8};
        port_ready = 4'b1110;
        write_rule(4'h1);
        build_packet(3);
        send_built("mc_leader", 3, 4'h1, 1'b1, 1'b0);
        peak = 0;
        for (int k = 0; k < 4; k++) begin
            write_rule(ports[k]);
            if (int'(cdp2um_rule_usedw) > peak) peak = int'(cdp2um_rule_usedw);
            n_checks++;
            if (cdp2um_rule_usedw !== 5'(k + 1)) begin
                n_fail++;
                $display("FAIL mc_usedw: got %0d, expected %0d", cdp2um_rule_usedw, k + 1);
            end
        end
        n_checks++;
        if (peak != 4) begin
            n_fail++;
            $display("FAIL mc_usedw_peak: got %0d, expected 4", peak);
        end
        port_ready = 4'hF;
        build_packet(3);
        for (int k = 0; k < 4; k++) send_built("mc", 3, ports[k], 1'b1, 1'b1);
        drain("mc");
        check_drop("mc");
    endtask

    task automatic test_invalid_rule();
        int seen;
        port_ready = 4'hF;
        write_rule(4'h3);
        build_packet(2);
        send_built("inv", 2, 4'h3, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 4'h0) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL inv_no_output: out_valid asserted %0d cycles, expected 0", seen);
        end
        exp_drop++;
        check_drop("inv");
        write_rule(4'h2);
        build_packet(2);
        send_built("inv_next", 2, 4'h2, 1'b1, 1'b0);
        drain("inv_next");
    endtask

    task automatic test_backpressure();
        int start, bad;
        port_ready = 4'b1011;
        start = cyc;
        write_rule(4'h4);
        build_packet(5);
        send_built("bp", 5, 4'h4, 1'b1, 1'b0);
        bad = 0;
        while (cyc - start < 20) begin
            if (out_valid !== 4'h0 || cdp2um_tx_enable !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d cycles with output or tx_enable, expected 0", bad);
        end
        port_ready = 4'hF;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== (i == 3 ? 4'b0100 : 4'h0)) begin
                n_fail++;
                $display("FAIL bp_release_c%0d: out_valid=%b, expected %b", i, out_valid, (i == 3 ? 4'b0100 : 4'h0));
            end
        end
        drain("bp");
    endtask

    task automatic test_rule_wrap();
        logic [3:0] rule_q[$];
        logic [3:0] r;
        bit ok;
        int extra;
        port_ready = 4'hF;
        write_rule(4'h1);
        wait_tx_enable("wrap_lead", ok);
        for (int i = 1; i <= 33; i++) begin
            r = 4'h1 << (i % 4);
            write_rule(r);
            if (i <= 32) rule_q.push_back(r);
            n_checks++;
            if (cdp2um_rule_usedw !== 5'(i <= 32 ? i % 32 : 0)) begin
                n_fail++;
                $display("FAIL wrap_usedw_w%0d: got %0d, expected %0d", i, cdp2um_rule_usedw, (i <= 32 ? i % 32 : 0));
            end
        end
        build_packet(2);
        send_built("wrap_lead", 2, 4'h1, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) begin
            r = rule_q.pop_front();
            build_packet(2);
            send_built("wrap", 2, r, 1'b1, 1'b0);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (cdp2um_tx_enable === 1'b1) extra++;
            @(negedge clk);
        end
        n_checks++;
        if (extra != 0 || cdp2um_rule_usedw !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_extra_grant: tx_enable cycles=%0d usedw=%0d, expected 0 and 0", extra, cdp2um_rule_usedw);
        end
        drain("wrap");
    endtask

    task automatic test_reset_mid_recv();
        port_ready = 4'hF;
        write_rule(4'h8);
        build_packet(6);
        for (int i = 0; i < 200 && cdp2um_tx_enable !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            um2cdp_data_valid = 1'b1;
            um2cdp_data       = pkt[i];
            @(negedge clk);
        end
        um2cdp_data_valid = 1'b0;
        reset = 1'b0;
        exp_drop = 0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        write_rule(4'h8);
        build_packet(2);
        send_built("after_reset", 2, 4'h8, 1'b1, 1'b0);
        drain("after_reset");
        check_drop("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_multicast();
        test_invalid_rule();
        test_backpressure();
        test_rule_wrap();
        test_reset_mid_recv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "global timeout");
    end
endmodule
